// File: rtl/kanade32_mem_pkg.sv
// ============================================================================
// Module      : kanade32_mem_pkg
// Description : Shared types and constants for the unified-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kanade32_mem_pkg;

    localparam int STARVE_CNT_W = 4;
    localparam int DEF_ADDR_W   = 30;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module      : ram_arbiter_if
// Description : Fetch/data request channels plus the RAM-side bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
    import kanade32_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ram_address, ram_data, ram_wren
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ram_address, ram_data, ram_wren
    );

endinterface

`default_nettype wire

// File: rtl/arb_starve_counter.sv
// ============================================================================
// Module      : arb_starve_counter
// Description : Saturating count of consecutive fetch-denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_counter
    import kanade32_mem_pkg::*;
#(
    parameter int MAX = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      at_max_o
);
    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    assign at_max_o = (cnt_q == STARVE_CNT_W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Data-priority fetch/data arbiter for a single-port RAM with a
//               starvation guard. Optional stats via RAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import kanade32_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ram_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_dm_grants,
    output logic [15:0] stat_starve_overrides
`endif
);
    owner_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, w_addr;
    logic [DATA_W-1:0] data_q, w_data;
    logic              w_at_max, w_if_gnt, w_dm_gnt;
    logic              w_unused_addr_bits;

    // Fetch only beats a pending data request once the starve count saturates.
    assign w_if_gnt = !reset && bus.if_req && (!bus.dm_req || w_at_max);
    assign w_dm_gnt = !reset && bus.dm_req && !(bus.if_req && w_at_max);

    arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (bus.if_req && !w_if_gnt),
        .clr_i    (w_if_gnt || !bus.if_req),
        .at_max_o (w_at_max)
    );

    always_comb begin
        w_addr = addr_q;
        if (w_if_gnt) begin
            w_addr = bus.if_addr[ADDR_W+1:2];
        end else if (w_dm_gnt) begin
            w_addr = bus.dm_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        w_data = data_q;
        if (w_dm_gnt && bus.dm_we) begin
            w_data = bus.dm_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= w_addr;
            data_q <= w_data;
        end
    end

    assign bus.if_gnt      = w_if_gnt;
    assign bus.dm_gnt      = w_dm_gnt;
    assign bus.ram_wren    = w_dm_gnt && bus.dm_we;
    assign bus.ram_address = reset ? '0 : w_addr;
    assign bus.ram_data    = reset ? '0 : w_data;
    assign bus.if_rdata    = bus.ram_q;
    assign bus.dm_rdata    = bus.ram_q;

    // Byte-lane bits and any bits above the word address are don't-care.
    assign w_unused_addr_bits = ^{bus.if_addr, bus.dm_addr};

    // Owner FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner FSM: next state from this cycle's grant type
    always_comb begin
        state_d = OWN_NONE;
        if (w_if_gnt) begin
            state_d = OWN_IF;
        end else if (w_dm_gnt && !bus.dm_we) begin
            state_d = OWN_DM;
        end
    end

    // Owner FSM: outputs; reset squashes any response still in flight
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.dm_rvalid = 1'b0;
        if (!reset) begin
            bus.if_rvalid = (state_q == OWN_IF);
            bus.dm_rvalid = (state_q == OWN_DM);
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_dm_q;
    logic [15:0] stat_ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_q  <= '0;
            stat_dm_q  <= '0;
            stat_ovr_q <= '0;
        end else begin
            if (w_if_gnt) stat_if_q <= stat_if_q + 32'd1;
            if (w_dm_gnt) stat_dm_q <= stat_dm_q + 32'd1;
            if (w_if_gnt && bus.dm_req) stat_ovr_q <= stat_ovr_q + 16'd1;
        end
    end

    assign stat_if_grants        = stat_if_q;
    assign stat_dm_grants        = stat_dm_q;
    assign stat_starve_overrides = stat_ovr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
    import kanade32_mem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter_if bus ();

`ifdef RAM_ARB_STATS_EN
    logic [31:0] s_if, s_dm;
    logic [15:0] s_ov;
`endif

    ram_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .stat_if_grants        (s_if),
        .stat_dm_grants        (s_dm),
        .stat_starve_overrides (s_ov)
`endif
    );

    // RAM model: unwritten words read back as 0xA000_0000 | word index.
    logic [31:0] mem [0:255];
    logic [255:0] written = '0;
    logic [31:0] q_r = '0;
    assign bus.ram_q = q_r;

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_address[7:0]]     <= bus.ram_data;
            written[bus.ram_address[7:0]] <= 1'b1;
        end
        q_r <= written[bus.ram_address[7:0]] ? mem[bus.ram_address[7:0]]
                                             : (32'hA000_0000 | {24'd0, bus.ram_address[7:0]});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dd);
        @(negedge clk);
        reset        = rst;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dwe;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        #1;
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0;
        bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

        // Reset with both requests pending: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 32'h10, 1, 1, 32'h20, 32'h5555_AAAA);
            check("rst_if_gnt", {31'd0, bus.if_gnt}, 0);
            check("rst_dm_gnt", {31'd0, bus.dm_gnt}, 0);
            check("rst_wren", {31'd0, bus.ram_wren}, 0);
            check("rst_addr", {2'd0, bus.ram_address}, 0);
            check("rst_data", bus.ram_data, 0);
            check("rst_rvalid", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 0);
        end

        // Fetch only
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h10, 0, 0, 0, 0);
            check("fetch_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h2);
            check("fetch_addr", {2'd0, bus.ram_address}, 32'h4);
            check("fetch_rvalid", {31'd0, bus.if_rvalid}, (i == 0) ? 0 : 1);
            if (i != 0) check("fetch_rdata", bus.if_rdata, 32'hA000_0004);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("fetch_tail_rvalid", {31'd0, bus.if_rvalid}, 1);
        check("idle_addr_hold", {2'd0, bus.ram_address}, 32'h4);
        check("idle_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("fetch_done_rvalid", {31'd0, bus.if_rvalid}, 0);

        // Contention from a clean reset: dm x4 then if, repeating.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 32'h10, 1, 0, 32'h20, 0);
            check("cont_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, (k % 5 == 4) ? 32'h2 : 32'h1);
            check("cont_addr", {2'd0, bus.ram_address}, (k % 5 == 4) ? 32'h4 : 32'h8);
            if (k == 4) check("cont_cnt_max", {28'd0, dut.u_starve.cnt_q}, 4);
            if (k == 5) check("cont_cnt_clr", {28'd0, dut.u_starve.cnt_q}, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("cont_tail_rvalid", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 32'h2);
        check("cont_tail_rdata", bus.if_rdata, 32'hA000_0004);
`ifdef RAM_ARB_STATS_EN
        check("stat_dm", s_dm, 8);
        check("stat_if", s_if, 2);
        check("stat_ovr", {16'd0, s_ov}, 2);
`endif

        // Store, then read it back
        cyc(0, 0, 0, 1, 1, 32'h104, 32'hDEAD_BEEF);
        check("st_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h1);
        check("st_wren", {31'd0, bus.ram_wren}, 1);
        check("st_addr", {2'd0, bus.ram_address}, 32'h41);
        check("st_data", bus.ram_data, 32'hDEAD_BEEF);
        cyc(0, 0, 0, 1, 0, 32'h104, 0);
        check("st_no_rvalid", {31'd0, bus.dm_rvalid}, 0);
        check("ld_wren", {31'd0, bus.ram_wren}, 0);
        check("ld_gnt", {31'd0, bus.dm_gnt}, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("ld_rvalid", {31'd0, bus.dm_rvalid}, 1);
        check("ld_rdata", bus.dm_rdata, 32'hDEAD_BEEF);

        // Back-to-back dm read then if read
        cyc(0, 0, 0, 1, 0, 32'h20, 0);
        check("b2b_dm_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h1);
        check("b2b_rv0", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 0);
        cyc(0, 1, 32'h40, 0, 0, 0, 0);
        check("b2b_if_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h2);
        check("b2b_if_addr", {2'd0, bus.ram_address}, 32'h10);
        check("b2b_rv1", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 32'h1);
        check("b2b_dm_rdata", bus.dm_rdata, 32'hA000_0008);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("b2b_rv2", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 32'h2);
        check("b2b_if_rdata", bus.if_rdata, 32'hA000_0010);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("b2b_rv3", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 0);

        // Reset while a data read is in flight
        cyc(0, 1, 32'h10, 1, 0, 32'h20, 0);
        check("mid_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h1);
        cyc(1, 1, 32'h10, 1, 0, 32'h20, 0);
        check("mid_rvalid", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 0);
        check("mid_gnt_rst", {30'd0, bus.if_gnt, bus.dm_gnt}, 0);
        check("mid_wren", {31'd0, bus.ram_wren}, 0);
        check("mid_addr", {2'd0, bus.ram_address}, 0);
        check("mid_data", bus.ram_data, 0);
        cyc(0, 1, 32'h10, 0, 0, 0, 0);
        check("post_cnt", {28'd0, dut.u_starve.cnt_q}, 0);
        check("post_gnt", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'h2);
        check("post_rvalid", {31'd0, bus.dm_rvalid}, 0);
        check("post_addr", {2'd0, bus.ram_address}, 32'h4);
        check("post_data", bus.ram_data, 0);

        cyc(0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
